// File: rtl/vga_sync_gen_if.sv
// Bundle of VGA timing outputs shared between the sync generator and
// the pixel/character generator that consumes the scan position.
interface vga_sync_gen_if;
   logic       p_tick;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       frame_start;

   // Sync generator drives the timing bundle
   modport master (
      output p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start
   );

   // Downstream pixel logic only observes it
   modport slave (
      input p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing front end: pixel-rate enable, horizontal/vertical scan
// counters, sync pulses, active-video flag and a start-of-frame strobe.
// Every output is a register loaded from the next-state counters so all
// of them change together on the same CLK edge.
module vga_sync_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int TICK_DIV  = 4,
   parameter int SYNC_POL  = 0
) (
   input  logic           CLK,
   input  logic           RESET,
   vga_sync_gen_if.master vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [4:0] TICK_MAX     = 5'(TICK_DIV - 1);
   localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic       SYNC_ACTIVE  = 1'(SYNC_POL);

   logic [4:0] r_tickCnt;
   logic       r_pTick;
   logic [9:0] r_pixX;
   logic [9:0] r_pixY;
   logic       r_videoOn;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_frameStart;

   logic [4:0] w_tickNext;
   logic       w_pTickNext;
   logic [9:0] w_xNext;
   logic [9:0] w_yNext;
   logic       w_hsActive;
   logic       w_vsActive;
   logic       w_videoNext;
   logic       w_frameNext;

   // Next-state scan position and the decodes that depend on it; the
   // counters step on the edge that ends a cycle in which p_tick is high
   always_comb begin
      w_tickNext  = (r_tickCnt == TICK_MAX) ? 5'd0 : r_tickCnt + 5'd1;
      w_pTickNext = (w_tickNext == TICK_MAX);
      w_xNext     = r_pixX;
      w_yNext     = r_pixY;
      if (r_pTick) begin
         if (r_pixX == H_MAX) begin
            w_xNext = 10'd0;
            w_yNext = (r_pixY == V_MAX) ? 10'd0 : r_pixY + 10'd1;
         end else begin
            w_xNext = r_pixX + 10'd1;
         end
      end
      w_hsActive  = (w_xNext >= H_SYNC_FIRST) && (w_xNext <= H_SYNC_LAST);
      w_vsActive  = (w_yNext >= V_SYNC_FIRST) && (w_yNext <= V_SYNC_LAST);
      w_videoNext = (w_xNext < H_VISIBLE) && (w_yNext < V_VISIBLE);
      w_frameNext = w_pTickNext && (w_xNext == 10'd0) && (w_yNext == 10'd0);
   end

   // Register the divider, counters and all timing outputs together
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_tickCnt    <= 5'd0;
         r_pTick      <= 1'b0;
         r_pixX       <= 10'd0;
         r_pixY       <= 10'd0;
         r_videoOn    <= 1'b1;
         r_hsync      <= ~SYNC_ACTIVE;
         r_vsync      <= ~SYNC_ACTIVE;
         r_frameStart <= 1'b0;
      end else begin
         r_tickCnt    <= w_tickNext;
         r_pTick      <= w_pTickNext;
         r_pixX       <= w_xNext;
         r_pixY       <= w_yNext;
         r_videoOn    <= w_videoNext;
         r_hsync      <= w_hsActive ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_vsync      <= w_vsActive ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_frameStart <= w_frameNext;
      end
   end

   assign vga.p_tick      = r_pTick;
   assign vga.pix_x       = r_pixX;
   assign vga.pix_y       = r_pixY;
   assign vga.video_on    = r_videoOn;
   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.frame_start = r_frameStart;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing front end of the VGA path: generates the pixel-rate enable, horizontal/vertical scan counters, sync pulses and active-video flag.
- Directly upstream of the character/graphics generator, which consumes pix_x/pix_y and drives graph_rgb.
- Default timing is 640x480 @ 60 Hz: 25 MHz pixel rate derived from a 100 MHz CLK.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 4, CLK cycles per pixel; legal values 1..16
- SYNC_POL, 0, sync active level; 0 = active-low, 1 = active-high

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- p_tick  out  1  one-CLK pixel enable, once every TICK_DIV cycles
- pix_x  out  10  horizontal count, 0..H_TOTAL-1
- pix_y  out  10  vertical count, 0..V_TOTAL-1
- video_on  out  1  high while pix_x<H_DISPLAY and pix_y<V_DISPLAY
- hsync  out  1  horizontal sync at SYNC_POL level
- vsync  out  1  vertical sync at SYNC_POL level
- frame_start  out  1  one-CLK pulse at the start of each frame

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
  - Both must be ≤1024.
- Reset: sampled on the rising CLK edge. After the reset edge:
  - tick counter=0, pix_x=0, pix_y=0, p_tick=0, frame_start=0
  - hsync=vsync=~SYNC_POL (inactive)
  - video_on=1
  - Applies equally when RESET is asserted mid-frame; no partial-line recovery.
- Tick divider:
  - Counts 0..TICK_DIV-1 and wraps.
  - p_tick=1 exactly in the cycles where the counter equals TICK_DIV-1.
  - TICK_DIV=1 → p_tick constantly 1 after the first post-reset cycle.
- Horizontal counter: advances only on p_tick; pix_x wraps from H_TOTAL-1 to 0.
- Vertical counter: pix_y increments on the same p_tick edge where pix_x wraps, and wraps from V_TOTAL-1 to 0.
- All outputs are registered and mutually consistent in every cycle: hsync, vsync and video_on are computed from the next-state counters and loaded on the same edge.
- hsync is active while H_DISPLAY+H_FRONT ≤ pix_x ≤ H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
- vsync is active while V_DISPLAY+V_FRONT ≤ pix_y ≤ V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491, for the full line width.
- video_on=0 at every blanking position.
- frame_start=1 for exactly the one CLK cycle in which p_tick=1 and pix_x=0, pix_y=0 (the first pixel of the frame is being presented).
- Pixel value hold:
  - Each (pix_x, pix_y) value is held for exactly TICK_DIV CLK cycles.
  - The downstream font ROM's 1-cycle latency is absorbed downstream and not compensated here.
- No outputs are X after the first reset edge.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1.

Test Plan:
- RESET held 3 cycles then released → pix_x=0, pix_y=0, hsync=vsync=1, video_on=1, p_tick=0; first p_tick on the 4th CLK after release; pix_x=1 one cycle after that tick.
- Free run one line → pix_x steps 0..799 then 0, pix_y 0→1 on the wrap tick; hsync low for exactly 96 ticks (384 CLK) starting at pix_x=656; video_on falls at pix_x=640.
- Free run one frame → vsync low only for pix_y=490..491 (1600 ticks); frame_start pulses once; frame period = 800×525×4 = 1,680,000 CLK.
- Corner wrap at pix_x=799, pix_y=524 → next tick gives (0,0), frame_start=1, video_on=1, hsync/vsync inactive.
- Assert RESET at pix_x=300, pix_y=200 mid-tick → next edge returns all outputs to reset values; counting restarts with p_tick after 4 CLK.
- TICK_DIV=1, SYNC_POL=1 → p_tick continuously high, pix_x advances every CLK; hsync high only at pix_x=656..751.
